// File: rtl/regfile_multiport.sv
// Multiport register bank for the ID stage: N_READ combinational read ports with
// write-through bypass, one general write port, a link-register port and a reset clear sweep.
module regfile_multiport #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int N_READ   = 2,
   parameter int LINK_REG = (1 << ADDR_W) - 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       hazard,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [DATA_W-1:0]          wdata,
   input  logic                       link,
   input  logic [DATA_W-1:0]          link_data,
   input  logic [N_READ*ADDR_W-1:0]   raddr,
   output logic [N_READ*DATA_W-1:0]   rdata,
   output logic                       busy,
   output logic                       link_conflict
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

   typedef enum logic {CLEAR, IDLE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                link_conflict_q, link_conflict_d;
   logic [DATA_W-1:0]   regs_q [DEPTH];

   logic gen_eff;
   logic link_eff;
   logic sweep_clr;

   assign busy          = (state_q == CLEAR);
   assign link_conflict = link_conflict_q;

   assign gen_eff   = we & ~hazard & ~busy & ~reset & (waddr != '0);
   assign link_eff  = link & ~hazard & ~busy & ~reset & (LINK_ADDR != '0);
   assign sweep_clr = (state_q == CLEAR) & ~reset;

   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (reset) begin
         state_d = CLEAR;
         cnt_d   = '0;
      end else if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = IDLE;
         end
      end
   end

   // Both writes hit LINK_REG: general write wins, flag it a cycle later.
   assign link_conflict_d = gen_eff & link_eff & (waddr == LINK_ADDR);

   always_ff @(posedge clk) begin
      if (reset) begin
         link_conflict_q <= 1'b0;
      end else begin
         link_conflict_q <= link_conflict_d;
      end
   end

   // Sweep clears and normal writes are exclusive because writes are gated by busy.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (sweep_clr && cnt_q == ADDR_W'(i)) begin
            regs_q[i] <= '0;
         end else if (gen_eff && waddr == ADDR_W'(i)) begin
            regs_q[i] <= wdata;
         end else if (link_eff && LINK_ADDR == ADDR_W'(i)) begin
            regs_q[i] <= link_data;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_READ; gi++) begin : g_rd
         logic [ADDR_W-1:0] ra;
         logic [DATA_W-1:0] rd;

         assign ra = raddr[gi*ADDR_W +: ADDR_W];

         always_comb begin
            rd = '0;
            if (busy || ra == '0) begin
               rd = '0;
            end else if (gen_eff && waddr == ra) begin
               rd = wdata;
            end else if (link_eff && ra == LINK_ADDR) begin
               rd = link_data;
            end else begin
               rd = regs_q[ra];
            end
         end

         assign rdata[gi*DATA_W +: DATA_W] = rd;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed bench for regfile_multiport: vector table for read/write/bypass/link behaviour,
// hand sequences for the reset sweep, writes blocked while busy and reset mid-sweep.
module tb_regfile_multiport;

   logic        clk;
   logic        reset;
   logic        hazard;
   logic        we;
   logic [4:0]  waddr;
   logic [31:0] wdata;
   logic        link;
   logic [31:0] link_data;
   logic [9:0]  raddr;
   logic [63:0] rdata;
   logic        busy;
   logic        link_conflict;

   int checks;
   int errors;

   regfile_multiport dut (
      .clk           (clk),
      .reset         (reset),
      .hazard        (hazard),
      .we            (we),
      .waddr         (waddr),
      .wdata         (wdata),
      .link          (link),
      .link_data     (link_data),
      .raddr         (raddr),
      .rdata         (rdata),
      .busy          (busy),
      .link_conflict (link_conflict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        hz;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        lk;
      logic [31:0] ld;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e0;
      logic [31:0] e1;
      logic        elc;
   } vec_t;

   vec_t vecs [14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   task automatic idle_inputs();
      hazard    = 1'b0;
      we        = 1'b0;
      waddr     = '0;
      wdata     = '0;
      link      = 1'b0;
      link_data = '0;
   endtask

   // Called at posedge+1; holds reset across exactly one edge.
   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Counts edges until busy falls; optionally attempts a write to addr 7 at sweep cycle wr_at.
   task automatic sweep_len(input int wr_at, output int n);
      n = 0;
      raddr = {5'd7, 5'd7};
      while (n < 100) begin
         if (n == wr_at) begin
            we = 1'b1; waddr = 5'd7; wdata = 32'h0000_0055;
         end else begin
            we = 1'b0;
         end
         #1;
         if (wr_at >= 0) check($sformatf("sweep_rd7_c%0d", n), rdata[31:0], 32'h0);
         @(posedge clk); #1;
         n++;
         if (!busy) break;
      end
      we = 1'b0;
   endtask

   initial begin
      int n;
      checks = 0;
      errors = 0;
      idle_inputs();
      raddr = '0;
      reset = 1'b1;

      // Reset state
      @(posedge clk); #1;
      check("rst_busy", {31'b0, busy}, 32'h1);
      check("rst_lc", {31'b0, link_conflict}, 32'h0);
      check("rst_rd0", rdata[31:0], 32'h0);
      check("rst_rd1", rdata[63:32], 32'h0);
      reset = 1'b0;

      sweep_len(-1, n);
      check("sweep_len", n, 32);

      for (int a = 0; a < 32; a++) begin
         raddr = {5'd0, 5'(a)};
         #1;
         check($sformatf("clr_rd_a%0d", a), rdata[31:0], 32'h0);
      end
      @(posedge clk); #1;

      //          hz    we    wa     wd            lk    ld            ra0    ra1    e0            e1            elc
      vecs[0]  = '{1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 32'h0,        5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        1'b0};
      vecs[2]  = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        1'b0};
      vecs[3]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 5'd31, 32'h12345678, 1'b1, 32'h00400010, 5'd31, 5'd31, 32'h12345678, 32'h12345678, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd31, 5'd0,  32'h12345678, 32'h0,        1'b0};
      vecs[6]  = '{1'b1, 1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 32'h00400010, 5'd31, 5'd31, 32'h12345678, 32'h12345678, 1'b0};
      vecs[7]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd31, 5'd5,  32'h12345678, 32'hDEADBEEF, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b1, 32'h00400010, 5'd31, 5'd5,  32'h00400010, 32'hDEADBEEF, 1'b0};
      vecs[9]  = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd31, 5'd31, 32'h00400010, 32'h00400010, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 5'd7,  32'hAAAA0000, 1'b1, 32'h11111111, 5'd7,  5'd31, 32'hAAAA0000, 32'h11111111, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd7,  5'd31, 32'hAAAA0000, 32'h11111111, 1'b0};
      vecs[12] = '{1'b1, 1'b1, 5'd9,  32'h00000099, 1'b0, 32'h0,        5'd9,  5'd7,  32'h0,        32'hAAAA0000, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0,        5'd9,  5'd5,  32'h0,        32'hDEADBEEF, 1'b0};

      for (int v = 0; v < 14; v++) begin
         hazard    = vecs[v].hz;
         we        = vecs[v].we;
         waddr     = vecs[v].wa;
         wdata     = vecs[v].wd;
         link      = vecs[v].lk;
         link_data = vecs[v].ld;
         raddr     = {vecs[v].ra1, vecs[v].ra0};
         #1;
         check($sformatf("v%0d_rd0", v), rdata[31:0], vecs[v].e0);
         check($sformatf("v%0d_rd1", v), rdata[63:32], vecs[v].e1);
         @(posedge clk); #1;
         check($sformatf("v%0d_lc", v), {31'b0, link_conflict}, {31'b0, vecs[v].elc});
      end
      idle_inputs();

      // Write attempted during the sweep must be dropped; reg7 must end cleared.
      do_reset();
      sweep_len(3, n);
      check("blk_sweep_len", n, 32);
      raddr = {5'd5, 5'd7};
      #1;
      check("blk_rd7_after", rdata[31:0], 32'h0);
      check("blk_rd5_after", rdata[63:32], 32'h0);
      @(posedge clk); #1;

      // Reset reasserted at sweep cycle 10 restarts the full sweep.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
      end
      check("mid_busy_c10", {31'b0, busy}, 32'h1);
      do_reset();
      check("mid_busy_rst", {31'b0, busy}, 32'h1);
      sweep_len(-1, n);
      check("mid_sweep_len", n, 32);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised register bank for the processor ID stage. It provides N_READ independent combinational read ports and one general write port with write-through bypass. A dedicated link port writes the return address into the link register. Reset runs a sequential clear sweep that zeroes one register per cycle, replacing a wide single-cycle clear.

## Interface

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- N_READ, 2, number of read ports (1..4)
- LINK_REG, DEPTH-1, index written by the link port

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  reset, synchronous, active-high
- hazard  in  1  stall; when 1, both write sources are suppressed this cycle
- we  in  1  general write enable
- waddr  in  ADDR_W  general write address
- wdata  in  DATA_W  general write data
- link  in  1  link write enable; target is LINK_REG
- link_data  in  DATA_W  link write data
- raddr  in  N_READ*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rdata  out  N_READ*DATA_W  packed read data; same packing as raddr
- busy  out  1  clear sweep in progress
- link_conflict  out  1  registered one-cycle pulse: link and general write both targeted LINK_REG in the same cycle

## Operation

- Register 0 is hardwired to zero. Writes to address 0 are discarded. Reads of address 0 return 0.
- Write qualification:
  - General write is effective when we & ~hazard & ~busy & ~reset & waddr != 0.
  - Link write is effective when link & ~hazard & ~busy & ~reset.
- Priority: if both effective writes target LINK_REG, the general write wins, link_data is dropped, and link_conflict pulses on the next cycle.
- Read port i, evaluated combinationally, in this order:
  - busy=1: returns 0.
  - raddr_i == 0: returns 0.
  - Effective general write to raddr_i this cycle: returns wdata (bypass).
  - Else, effective link write and raddr_i == LINK_REG: returns link_data.
  - Else: returns the stored value.
- Clear sweep, two states: CLEAR and IDLE.
  - reset=1: next state CLEAR, sweep counter cnt <= 0, busy <= 1.
  - In CLEAR with reset=0: reg[cnt] <= 0 and cnt <= cnt+1. When cnt == DEPTH-1, next state is IDLE and busy <= 0.
  - IDLE: normal operation. No path returns to CLEAR except reset.
- Reset asserted mid-sweep restarts the sweep at cnt=0.
- All read ports are independent. Any number of ports may read the same address.

## Timing

- Reset values, after a clock edge with reset=1: busy=1, link_conflict=0, cnt=0, rdata=0.
- Sweep length: busy falls exactly DEPTH cycles after the first edge with reset=0. With the defaults this is 32 cycles. The first write is accepted on the edge after busy is observed low.
- Write latency: data is stored on the rising edge. It is visible the same cycle through the bypass, and from storage on every following cycle.
- link_conflict is high for exactly one cycle, the cycle after the conflicting edge. It is 0 whenever hazard or busy suppressed either write.
- hazard is purely combinational gating; it holds no state.
- Stored contents are not guaranteed before the first reset. The test bench must reset first.

## Test plan

- Reset, then idle: assert reset for 1 cycle, then release. busy stays 1 for 32 cycles then falls; all rdata read 0. Reading every address afterward returns 0.
- Write/read with bypass: we=1, waddr=5, wdata=0xDEADBEEF, raddr0=5 in the same cycle. rdata0=0xDEADBEEF combinationally; after the edge it reads from storage, still 0xDEADBEEF. raddr1=5 gives the same value.
- Register 0: we=1, waddr=0, wdata=0xFFFFFFFF. rdata for address 0 stays 0 before and after the edge.
- Link conflict: link=1, link_data=0x00400010, we=1, waddr=31, wdata=0x12345678. reg31 becomes 0x12345678; link_conflict=1 for the next cycle only. The same stimulus with hazard=1 leaves reg31 unchanged and link_conflict=0.
- Write blocked while busy: write 0xAAAA0000 to addr 7. Assert reset, release it, and attempt we=1, waddr=7, wdata=0x55 at sweep cycle 3. rdata for address 7 is 0 throughout the sweep and still 0 after busy falls.
- Reset mid-sweep: reassert reset at sweep cycle 10. busy stays high, and it falls 32 cycles after the second reset is released.
